// File: rtl/regfile_sb.sv
// regfile_sb: parameterised multi-read-port register file with a per-register
// busy scoreboard (reserve from decode, release on writeback, flush via clr).
// Register 0 is hardwired to zero and can never be reserved.
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write-to-read bypass
// on every read port. Without it, reads show stored state only.

// One read port: indexes storage and the scoreboard, applies the zero register
// and, when enabled, the writeback bypass.
module regfile_sb_rdport #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] mem,
  input  logic [NUM_REGS-1:0]             busy,
  input  logic [ADDR_W-1:0]               addr,
  input  logic                            wr_hit,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               data,
  output logic                            busy_bit
);

`ifndef REGFILE_BYPASS_EN
  // Writeback signals only matter to the bypass mux.
  logic unused_bypass;
  assign unused_bypass = ^{wr_hit, wr_addr, wr_data};
`endif

  // Stored value / busy bit, zero register forced to 0, then optional bypass.
  always_comb begin
    data     = mem[addr];
    busy_bit = busy[addr];
    if (addr == '0) begin
      data     = '0;
      busy_bit = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    // wr_hit already excludes register 0, so no conflict with the override above.
    if (wr_hit && (addr == wr_addr)) begin
      data     = wr_data;
      busy_bit = 1'b0;
    end
`endif
  end

endmodule

module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_W-1:0]              rsv_addr,
  output logic                           rsv_ready,
  input  logic                           clr,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic [ADDR_W:0]                busy_cnt
);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_REGS-1:0]             busy, busy_nxt;
  logic [ADDR_W:0]                 cnt, cnt_nxt;
  logic                            wr_hit, rel_same, dec;

  // A writeback to a real register; register 0 writes are dropped entirely.
  assign wr_hit   = wr_en && (wr_addr != '0);
  // Releasing the very register decode wants lets the new producer in (WAW ok).
  assign rel_same = wr_hit && (wr_addr == rsv_addr);
  // Reservation depends only on rsv_*/wr_*/clr and state, never on rd_addr.
  assign rsv_ready = rsv_en && !clr && (rsv_addr != '0) &&
                     (!busy[rsv_addr] || rel_same);
  // Release only lowers the count if the register was actually busy.
  assign dec = wr_hit && busy[wr_addr];

  // Next scoreboard: release, then reserve (new producer wins), clr overrides.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit)    busy_nxt[wr_addr]  = 1'b0;
    if (rsv_ready) busy_nxt[rsv_addr] = 1'b1;
    if (clr)       busy_nxt           = '0;
    busy_nxt[0] = 1'b0;
  end

  // Incremental popcount kept in step with busy; same-register hit nets to 0.
  always_comb begin
    cnt_nxt = cnt + {{ADDR_W{1'b0}}, rsv_ready} - {{ADDR_W{1'b0}}, dec};
    if (clr) cnt_nxt = '0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Storage; clr does not block data writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        mem          <= '0;
    else if (wr_hit) mem[wr_addr] <= wr_data;
  end

  assign busy_vec = busy;
  assign busy_cnt = cnt;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W)
    ) u_rdport (
      .mem     (mem),
      .busy    (busy),
      .addr    (rd_addr[p]),
      .wr_hit  (wr_hit),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[p]),
      .busy_bit(rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against an
// array-based reference model of the register file and scoreboard.
module tb_regfile_sb;
  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int NP = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NP*AW-1:0] rd_addr = '0;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             rsv_en = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;
  logic             rsv_ready;
  logic             clr = 1'b0;
  logic [NR-1:0]    busy_vec;
  logic [AW:0]      busy_cnt;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [DW-1:0] m_mem [NR];
  bit            m_busy[NR];

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .clr(clr),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] port_addr(int p);
    return rd_addr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] port_data(int p);
    return rd_data[p*DW +: DW];
  endfunction

  function automatic bit exp_ready();
    if (!rsv_en || clr || rsv_addr == 0) return 1'b0;
    if (!m_busy[rsv_addr]) return 1'b1;
    return wr_en && wr_addr == rsv_addr;
  endfunction

  function automatic logic [DW-1:0] exp_data(int p);
    int a = int'(port_addr(p));
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != 0 && int'(wr_addr) == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic bit exp_rbusy(int p);
    int a = int'(port_addr(p));
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != 0 && int'(wr_addr) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] exp_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return (AW+1)'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Apply the architectural rules for one clock edge using the held inputs.
  task automatic model_edge();
    bit acc;
    if (!rst) begin
      model_reset();
      return;
    end
    acc = exp_ready();
    if (wr_en && wr_addr != 0) begin
      m_mem[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (acc) m_busy[rsv_addr] = 1'b1;
    if (clr) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    repeat (2) tick();
    rst = 1;
    for (int a = 0; a < NR; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1;
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (port_data(p) !== '0) begin
          errors++; $display("FAIL reset_rd_data a=%0d p=%0d got %h exp 0", a, p, port_data(p));
        end
      end
    end
    checks++;
    if (busy_vec !== '0 || busy_cnt !== '0) begin
      errors++; $display("FAIL reset_busy got vec=%h cnt=%0d exp 0/0", busy_vec, busy_cnt);
    end
    tick();
  endtask

  task automatic test_waw();
    rsv_en = 1; rsv_addr = 3; #1;
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL waw_first_ready got %b exp 1", rsv_ready); end
    tick();
    checks++;
    if (rsv_ready !== 1'b0) begin errors++; $display("FAIL waw_second_ready got %b exp 0", rsv_ready); end
    tick();
    rsv_en = 0; #1;
    checks++;
    if (busy_cnt !== 1 || busy_vec[3] !== 1'b1) begin
      errors++; $display("FAIL waw_cnt got cnt=%0d b3=%b exp 1/1", busy_cnt, busy_vec[3]);
    end
    wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
    tick();
    idle(); rd_addr = {AW'(0), AW'(3)}; #1;
    checks++;
    if (busy_vec[3] !== 1'b0 || busy_cnt !== 0) begin
      errors++; $display("FAIL waw_release got b3=%b cnt=%0d exp 0/0", busy_vec[3], busy_cnt);
    end
    checks++;
    if (port_data(0) !== 16'hBEEF) begin errors++; $display("FAIL waw_rdata got %h exp beef", port_data(0)); end
  endtask

  task automatic test_same_reg();
    rsv_en = 1; rsv_addr = 5; tick();
    wr_en = 1; wr_addr = 5; wr_data = 16'h1234; #1;
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b exp 1", rsv_ready); end
    tick();
    idle(); rd_addr = {AW'(5), AW'(5)}; #1;
    checks++;
    if (busy_vec[5] !== 1'b1 || busy_cnt !== 1) begin
      errors++; $display("FAIL same_busy got b5=%b cnt=%0d exp 1/1", busy_vec[5], busy_cnt);
    end
    checks++;
    if (port_data(1) !== 16'h1234) begin errors++; $display("FAIL same_rdata got %h exp 1234", port_data(1)); end
  endtask

  task automatic test_reg0();
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; rsv_en = 1; rsv_addr = 0; #1;
    checks++;
    if (rsv_ready !== 1'b0) begin errors++; $display("FAIL r0_ready got %b exp 0", rsv_ready); end
    tick();
    idle(); rd_addr = '0; #1;
    checks++;
    if (port_data(0) !== '0 || busy_vec[0] !== 1'b0) begin
      errors++; $display("FAIL r0_read got %h b0=%b exp 0/0", port_data(0), busy_vec[0]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] old;
    old = m_mem[7];
    wr_en = 1; wr_addr = 7; wr_data = 16'hA5A5; rd_addr = {AW'(7), AW'(7)}; #1;
    for (int p = 0; p < NP; p++) begin
      checks++;
`ifdef REGFILE_BYPASS_EN
      if (port_data(p) !== 16'hA5A5 || rd_busy[p] !== 1'b0) begin
        errors++; $display("FAIL bypass_same p=%0d got %h/%b exp a5a5/0", p, port_data(p), rd_busy[p]);
      end
`else
      if (port_data(p) !== old) begin
        errors++; $display("FAIL nobypass_same p=%0d got %h exp %h", p, port_data(p), old);
      end
`endif
    end
    tick();
    idle(); #1;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (port_data(p) !== 16'hA5A5) begin
        errors++; $display("FAIL bypass_next p=%0d got %h exp a5a5", p, port_data(p));
      end
    end
  endtask

  task automatic test_clr_reset();
    rsv_en = 1;
    rsv_addr = 1; tick();
    rsv_addr = 2; tick();
    rsv_addr = 4; tick();
    clr = 1; rsv_addr = 6; #1;
    checks++;
    if (rsv_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b exp 0", rsv_ready); end
    tick();
    idle(); #1;
    checks++;
    if (busy_vec !== '0 || busy_cnt !== 0) begin
      errors++; $display("FAIL clr_busy got vec=%h cnt=%0d exp 0/0", busy_vec, busy_cnt);
    end
    rsv_en = 1; rsv_addr = 9; tick();
    rsv_en = 0; wr_en = 1; wr_addr = 10; wr_data = 16'h5555; tick();
    idle(); rd_addr = {AW'(10), AW'(9)}; #1;
    rst = 0; model_reset(); #1;
    checks++;
    if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0 || busy_cnt !== '0) begin
      errors++; $display("FAIL async_reset got rd=%h rb=%b vec=%h cnt=%0d exp all 0", rd_data, rd_busy, busy_vec, busy_cnt);
    end
    tick();
    rst = 1; #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rd_addr  = (NP*AW)'($urandom);
      wr_en    = ($urandom % 2) == 0;
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      rsv_en   = ($urandom % 4) != 0;
      rsv_addr = (($urandom % 4) == 0) ? wr_addr : AW'($urandom);
      clr      = ($urandom % 25) == 0;
      if (($urandom % 3) == 0) rd_addr[AW-1:0] = wr_addr;
      #1;
      checks++;
      if (rsv_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, rsv_ready, exp_ready());
      end
      checks++;
      if (busy_vec !== exp_vec() || busy_cnt !== exp_cnt()) begin
        errors++; $display("FAIL rnd_busy c=%0d got %h/%0d exp %h/%0d", c, busy_vec, busy_cnt, exp_vec(), exp_cnt());
      end
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (port_data(p) !== exp_data(p) || rd_busy[p] !== exp_rbusy(p)) begin
          errors++; $display("FAIL rnd_read c=%0d p=%0d got %h/%b exp %h/%b", c, p, port_data(p), rd_busy[p], exp_data(p), exp_rbusy(p));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_waw();
    test_same_reg();
    test_reg0();
    test_bypass();
    test_clr_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
